// File: rtl/fproc_client_if.sv
// Bundle between a proc core's decoder/register-write path and the fproc hub.
// A decoder request transfers on a clock edge where req_valid and req_ready are both 1;
// req_valid must then be held by the decoder until that edge.
interface fproc_client_if #(
  parameter int FPROC_ID_WIDTH = 8,
  parameter int DATA_WIDTH     = 32
);
  logic                      req_valid;
  logic [FPROC_ID_WIDTH-1:0] req_id;
  logic                      req_ready;
  logic                      stall;
  logic                      result_valid;
  logic [DATA_WIDTH-1:0]     result_data;
  logic                      result_err;
  logic                      fproc_enable;
  logic [FPROC_ID_WIDTH-1:0] fproc_id;
  logic                      fproc_ready;
  logic [DATA_WIDTH-1:0]     fproc_data;
  logic                      spurious_ready;

  modport master (
    input  req_valid, req_id, fproc_ready, fproc_data,
    output req_ready, stall, result_valid, result_data, result_err,
           fproc_enable, fproc_id, spurious_ready
  );

  modport slave (
    output req_valid, req_id, fproc_ready, fproc_data,
    input  req_ready, stall, result_valid, result_data, result_err,
           fproc_enable, fproc_id, spurious_ready
  );
endinterface

// File: rtl/fproc_client.sv
// Core-side fproc requester: issues one read to the hub, stalls the core until
// the hub answers or the timeout expires, then pulses the result for one cycle.
module fproc_client #(
  parameter int FPROC_ID_WIDTH = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  fproc_client_if.master    bus,
  output logic [1:0]        fsm_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic [FPROC_ID_WIDTH-1:0] id_q;
  logic                      res_valid_q;
  logic [DATA_WIDTH-1:0]     res_data_q;
  logic                      res_err_q;
  logic                      spurious_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      id_q        <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      spurious_q  <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          // A hub strobe with nothing outstanding carries no usable data.
          if (bus.fproc_ready) spurious_q <= 1'b1;
          if (bus.req_valid) begin
            id_q  <= bus.req_id;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          cnt <= CNT_W'(1);
          if (bus.fproc_ready) begin
            res_data_q  <= bus.fproc_data;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b1;
            state       <= IDLE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '1) cnt <= cnt + CNT_W'(1);
          // A response in the timeout cycle still counts as a good answer.
          if (bus.fproc_ready) begin
            res_data_q  <= bus.fproc_data;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b1;
            state       <= IDLE;
          end else if (TIMEOUT_CYCLES != 0 && cnt == TIMEOUT_VAL) begin
            res_data_q  <= '0;
            res_err_q   <= 1'b1;
            res_valid_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready      = (state == IDLE);
  assign bus.stall          = (state != IDLE);
  assign bus.fproc_enable   = (state == ISSUE);
  assign bus.fproc_id       = id_q;
  assign bus.result_valid   = res_valid_q;
  assign bus.result_data    = res_data_q;
  assign bus.result_err     = res_err_q;
  assign bus.spurious_ready = spurious_q;
  assign fsm_state          = state;

endmodule

// File: doc/fproc_client.md
Name: fproc_client

Overview:
- Core-side requester for the fproc interface; the counterpart of the function-processor hub (measurement/LUT distributor) that answers fproc requests.
- Sits in each proc core between the instruction decoder and that core's fproc interface.
- Accepts one fproc read request from the decoder and drives `fproc_enable` / `fproc_id` to the hub.
- Stalls the core until the hub returns `fproc_ready` with data, or a timeout expires, then delivers the result (or an error) to the register-write path.

Parameters:
- FPROC_ID_WIDTH, 8, width of the fproc function id (0 = control-qubit measurement, 1 = LUT output, others hub-defined).
- DATA_WIDTH, 32, width of the returned fproc data word.
- TIMEOUT_CYCLES, 4096, max cycles to wait for `fproc_ready` after issue; 0 disables the timeout.

Ports:
- clk  in  1  core clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  decoder requests an fproc read.
- req_id  in  FPROC_ID_WIDTH  function id for the request.
- req_ready  out  1  block can accept a request; a request transfers when `req_valid` and `req_ready` are both 1 at a clock edge.
- stall  out  1  core pipeline hold while a request is outstanding.
- result_valid  out  1  one-cycle pulse; result fields valid.
- result_data  out  DATA_WIDTH  captured `fproc_data`, or 0 on timeout.
- result_err  out  1  qualifies `result_valid`: 1 = timeout.
- fproc_enable  out  1  one-cycle request strobe to the hub.
- fproc_id  out  FPROC_ID_WIDTH  request id; held stable from the `fproc_enable` cycle until completion.
- fproc_ready  in  1  hub response strobe.
- fproc_data  in  DATA_WIDTH  hub response data; valid when `fproc_ready` = 1.
- spurious_ready  out  1  sticky flag: `fproc_ready` seen with no request outstanding.

Behaviour:
- Reset (`reset` = 0 at an edge):
  - FSM returns to IDLE; the timeout counter clears.
  - Outputs: `req_ready` = 1 once reset deasserts; `stall` = 0; `result_valid` = 0; `result_data` = 0; `result_err` = 0; `fproc_enable` = 0; `fproc_id` = 0; `spurious_ready` = 0.
  - Reset mid-request abandons the request with no result pulse. A late `fproc_ready` after reset sets `spurious_ready`.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - `req_ready` = 1, `stall` = 0.
  - On transfer (`req_valid` & `req_ready`): latch `req_id` into `fproc_id`, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - `fproc_enable` = 1, `stall` = 1, `req_ready` = 0.
  - Timeout counter loads 1.
  - If `fproc_ready` = 1 this cycle: capture `fproc_data`, complete (see Completion), go to IDLE. Otherwise go to WAIT.
- WAIT:
  - `fproc_enable` = 0, `stall` = 1, `req_ready` = 0.
  - Counter increments each cycle, saturating.
  - On `fproc_ready` = 1: capture `fproc_data`, complete, go to IDLE.
  - Else if TIMEOUT_CYCLES ≠ 0 and counter = TIMEOUT_CYCLES: complete with error, go to IDLE.
  - If `fproc_ready` arrives in the same cycle the counter reaches TIMEOUT_CYCLES, `ready` wins (no error).
- Completion:
  - Registered. In the first IDLE cycle after completion: `result_valid` = 1 for exactly one cycle, `stall` = 0.
  - `result_data` = captured data (or 0 on error); `result_err` = 1 only on timeout.
  - `result_data` and `result_err` hold their values until the next completion.
- Latency:
  - Transfer at edge T → `fproc_enable` high in cycle T+1.
  - `fproc_ready` in cycle T+k (k ≥ 1) → `result_valid` in cycle T+k+1.
  - Minimum request-to-result latency is 2 cycles.
- Back-to-back requests: `req_ready` = 1 in the same cycle as `result_valid`, so a new request may transfer then. `result_*` for the old request is still valid that cycle.
- `fproc_ready` in IDLE (including the `result_valid` cycle) is ignored for data and sets `spurious_ready`. The flag is cleared only by reset.
- Only one request may be outstanding; there is no queueing. `req_valid` while `req_ready` = 0 is held by the decoder, not dropped by this block.
- `fproc_id` does not change during ISSUE or WAIT, even if `req_id` changes.

Test Plan:
- Basic:
  - Stimulus: reset low 3 cycles, then high; `req_valid`=1, `req_id`=0 for one cycle; hub returns `fproc_ready`=1, `fproc_data`=0x1 two cycles after `fproc_enable`.
  - Required: `fproc_enable` pulses 1 cycle with `fproc_id`=0; `stall`=1 for 3 cycles; `result_valid` 1 cycle with `result_data`=0x1, `result_err`=0.
- Same-cycle response:
  - Stimulus: `fproc_ready`=1, `fproc_data`=0xA5 during the `fproc_enable` cycle.
  - Required: `result_valid` the next cycle with 0xA5; total stall 1 cycle.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8, hub never responds.
  - Required: `result_valid`=1 with `result_err`=1 and `result_data`=0 exactly 9 cycles after `fproc_enable`.
  - Variant: `ready` exactly at the timeout cycle → `result_err`=0, data captured.
- Back-to-back:
  - Stimulus: `req_id`=1, then `req_id`=0 issued in the `result_valid` cycle; responses 0x1 then 0x0.
  - Required: second `fproc_enable` one cycle after the first `result_valid`; results in order.
- Spurious / ID hold:
  - Stimulus: `fproc_ready` pulse while idle; `req_id` toggled during WAIT.
  - Required: `spurious_ready`=1 and no `result_valid`; `fproc_id` stays at the latched value.
- Reset mid-WAIT:
  - Stimulus: assert `reset`=0 during WAIT, then release.
  - Required: all outputs return to reset values, no `result_valid`; a following request completes normally.
